gat_feat_reader: RTL and testbench

GAT_FEAT_READER -- requirements
Module: gat_feat_reader

---
 rtl/gat_feat_reader.sv | 191 +++++++++++++++++++
 tb/tb_gat_feat_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_feat_reader.sv
// -----------------------------------------------------------------------------
// gat_feat_reader
//
// Streams one frame of GAT output features from a feature BRAM onto an
// AXI-Stream style master port.  A frame is started by a rising edge of
// gat_ready.  Words are read in ascending order 0 .. NEW_FEATURE_DEPTH-1.
// A 2-entry output buffer plus a one-deep in-flight tracker absorb the
// 1-cycle BRAM read latency and downstream backpressure without loss.
//
// Configuration macro:
//   FEAT_READER_ROW_LAST_EN  defined   : m_tlast on every row end
//                                        (index mod NUM_FEATURE_OUT == NUM_FEATURE_OUT-1)
//                            undefined : m_tlast only on the frame's final word
//
// Ports:
//   clk              in   clock, all logic on rising edge
//   rst              in   synchronous active-high reset
//   gat_ready        in   accelerator result-complete flag (rising edge starts a frame)
//   feat_bram_addrb  out  BRAM byte address (word index << 2)
//   feat_bram_dout   in   BRAM read data, valid 1 cycle after address
//   m_tdata          out  streamed feature word
//   m_tvalid         out  stream valid
//   m_tready         in   stream ready
//   m_tlast          out  stream last marker
//   busy             out  frame in progress (READ or DRAIN)
//   done             out  frame complete, waiting for gat_ready low
//   word_cnt         out  words accepted downstream in the current frame
// -----------------------------------------------------------------------------
module gat_feat_reader #(
   parameter int NEW_FEATURE_WIDTH  = 32,
   parameter int NUM_SUBGRAPHS      = 2708,
   parameter int NUM_FEATURE_OUT    = 16,
   parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
   parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          gat_ready,
   output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
   input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
   output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic                          m_tlast,
   output logic                          busy,
   output logic                          done,
   output logic [NEW_FEATURE_ADDR_W:0]   word_cnt
);

   localparam int AW = NEW_FEATURE_ADDR_W;
   localparam logic [AW:0] LAST_IDX = (AW+1)'(NEW_FEATURE_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t state_q, state_d;

   logic                         gat_q;
   logic                         start_frame;
   logic [AW:0]                  rd_idx_q, rd_idx_d;
   logic [AW:0]                  issue_idx;
   logic                         issue, issue_final, issue_last;
   logic                         inflight_q, inflight_last_q;
   logic [NEW_FEATURE_WIDTH-1:0] buf_data_q [2];
   logic                         buf_last_q [2];
   logic                         wr_ptr_q, rd_ptr_q;
   logic [1:0]                   count_q, count_d;
   logic [2:0]                   slots_used;
   logic                         push, pop;
   logic [AW:0]                  word_cnt_q, word_cnt_d;
   logic                         frame_end;

   // gat_q resets to 1 so a level-high gat_ready at reset exit is not an edge.
   assign start_frame = (state_q == S_IDLE) & gat_ready & ~gat_q;
   assign push        = inflight_q;
   assign pop         = (count_q != 2'd0) & m_tready;
   assign frame_end   = pop & (word_cnt_q == LAST_IDX);

   // The first read is issued in the start-edge cycle itself (index 0) so the
   // first word is valid two cycles after the edge.  A word popped this cycle
   // frees its slot immediately, which sustains one word per cycle.
   always_comb begin : issue_logic
      issue_idx   = (state_q == S_READ) ? rd_idx_q : '0;
      slots_used  = 3'(count_q) + 3'(inflight_q) - 3'(pop);
      issue       = ((state_q == S_READ) | start_frame) & (slots_used < 3'd2);
      issue_final = issue & (issue_idx == LAST_IDX);
      rd_idx_d    = issue ? issue_idx + (AW+1)'(1) : rd_idx_q;
   end

`ifdef FEAT_READER_ROW_LAST_EN
   localparam int CW = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(NUM_FEATURE_OUT - 1);

   logic [CW-1:0] col_q, col_d, issue_col;

   // Column position tracked alongside the read index instead of a modulo.
   always_comb begin : row_last_logic
      issue_col  = (state_q == S_READ) ? col_q : '0;
      issue_last = (issue_col == LAST_COL);
      col_d      = col_q;
      if (issue) begin
         col_d = (issue_col == LAST_COL) ? '0 : issue_col + CW'(1);
      end
   end

   always_ff @(posedge clk) begin : col_reg
      if (rst) begin
         col_q <= '0;
      end else begin
         col_q <= col_d;
      end
   end
`else
   always_comb begin : frame_last_logic
      issue_last = (issue_idx == LAST_IDX);
   end
`endif

   always_comb begin : counter_logic
      count_d = count_q + 2'(push) - 2'(pop);
      if (start_frame) begin
         word_cnt_d = '0;
      end else if (pop) begin
         word_cnt_d = word_cnt_q + (AW+1)'(1);
      end else begin
         word_cnt_d = word_cnt_q;
      end
   end

   // Clearing inflight_q on reset discards any BRAM data still returning.
   always_ff @(posedge clk) begin : datapath_reg
      if (rst) begin
         gat_q           <= 1'b1;
         rd_idx_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         buf_data_q[0]   <= '0;
         buf_data_q[1]   <= '0;
         buf_last_q[0]   <= 1'b0;
         buf_last_q[1]   <= 1'b0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         count_q         <= '0;
         word_cnt_q      <= '0;
      end else begin
         gat_q           <= gat_ready;
         rd_idx_q        <= rd_idx_d;
         inflight_q      <= issue;
         inflight_last_q <= issue & issue_last;
         if (push) begin
            buf_data_q[wr_ptr_q] <= feat_bram_dout;
            buf_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q    <= count_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   always_ff @(posedge clk) begin : state_reg
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : next_state_logic
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_frame) state_d = issue_final ? S_DRAIN : S_READ;
         S_READ:  if (issue_final) state_d = S_DRAIN;
         S_DRAIN: if (frame_end)   state_d = S_DONE;
         S_DONE:  if (!gat_ready)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin : output_logic
      busy            = (state_q == S_READ) | (state_q == S_DRAIN);
      done            = (state_q == S_DONE);
      m_tvalid        = (count_q != 2'd0);
      m_tdata         = m_tvalid ? buf_data_q[rd_ptr_q] : '0;
      m_tlast         = m_tvalid & buf_last_q[rd_ptr_q];
      feat_bram_addrb = {issue_idx[AW-1:0], 2'b00};
      word_cnt        = word_cnt_q;
   end

endmodule

// File: tb/tb_gat_feat_reader.sv
// -----------------------------------------------------------------------------
// tb_gat_feat_reader
//
// Self-checking bench for gat_feat_reader with NUM_SUBGRAPHS=3,
// NUM_FEATURE_OUT=4 (12 words per frame).  The BRAM model returns
// 0x100 + word index one cycle after the address.  Expected stream contents
// come from a small reference model of the frame (word value and last flag
// per index).  Honors FEAT_READER_ROW_LAST_EN for the m_tlast rule.
// -----------------------------------------------------------------------------
module tb_gat_feat_reader;

   localparam int NS    = 3;
   localparam int NFO   = 4;
   localparam int DEPTH = NS * NFO;
   localparam int W     = 32;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          gat_ready = 1'b0;
   logic          m_tready = 1'b0;
   logic [AW+1:0] feat_bram_addrb;
   logic [W-1:0]  feat_bram_dout;
   logic [W-1:0]  m_tdata;
   logic          m_tvalid, m_tlast, busy, done;
   logic [AW:0]   word_cnt;

   int checks = 0;
   int errors = 0;

   logic          v_log[$], r_log[$], l_log[$], busy_log[$], done_log[$];
   logic [W-1:0]  d_log[$];
   logic [AW+1:0] a_log[$];
   logic [AW:0]   wc_log[$];
   logic [W-1:0]  hs_d[$];
   logic          hs_l[$];
   bit            timed_out;

   gat_feat_reader #(
      .NEW_FEATURE_WIDTH(W),
      .NUM_SUBGRAPHS(NS),
      .NUM_FEATURE_OUT(NFO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .gat_ready(gat_ready),
      .feat_bram_addrb(feat_bram_addrb),
      .feat_bram_dout(feat_bram_dout),
      .m_tdata(m_tdata),
      .m_tvalid(m_tvalid),
      .m_tready(m_tready),
      .m_tlast(m_tlast),
      .busy(busy),
      .done(done),
      .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   // BRAM model: word i holds 0x100 + i, one cycle read latency.
   always_ff @(posedge clk) feat_bram_dout <= 32'h100 + 32'(feat_bram_addrb >> 2);

   // Reference model of one frame.
   function automatic logic [W-1:0] exp_data(input int i);
      return 32'h100 + 32'(i);
   endfunction

   function automatic logic exp_last(input int i);
`ifdef FEAT_READER_ROW_LAST_EN
      return (i % NFO) == (NFO - 1);
`else
      return i == (DEPTH - 1);
`endif
   endfunction

   // Runs cycles after a start edge, logging outputs at each falling edge,
   // until done is seen or the budget expires.  mode 0: ready held high,
   // mode 1: ready 1,0,0,1 repeating, other: random ready.  gat_ready is
   // dropped once drop_at words have been handshaken (drop_at < 0: never).
   task automatic capture(input int mode, input int drop_at, input int budget);
      int hs;
      hs = 0;
      timed_out = 1'b1;
      v_log.delete(); r_log.delete(); l_log.delete(); d_log.delete();
      a_log.delete(); busy_log.delete(); done_log.delete(); wc_log.delete();
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ((c % 4) == 0) || ((c % 4) == 3);
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
         #1;
         v_log.push_back(m_tvalid);
         r_log.push_back(m_tready);
         d_log.push_back(m_tdata);
         l_log.push_back(m_tlast);
         a_log.push_back(feat_bram_addrb);
         busy_log.push_back(busy);
         done_log.push_back(done);
         wc_log.push_back(word_cnt);
         if (m_tvalid && m_tready) hs++;
         if (drop_at >= 0 && hs >= drop_at) gat_ready = 1'b0;
         if (done) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic extract();
      hs_d.delete();
      hs_l.delete();
      foreach (v_log[i]) begin
         if (v_log[i] && r_log[i]) begin
            hs_d.push_back(d_log[i]);
            hs_l.push_back(l_log[i]);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; gat_ready = 1'b0; m_tready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (feat_bram_addrb !== '0) begin errors++; $display("FAIL reset_addrb got %0h exp 0", feat_bram_addrb); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b exp 0", m_tvalid); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %0b exp 0", m_tlast); end
      checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %0h exp 0", m_tdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
      checks++; if (word_cnt !== '0) begin errors++; $display("FAIL reset_word_cnt got %0d exp 0", word_cnt); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int first_v;
      @(negedge clk);
      gat_ready = 1'b1; m_tready = 1'b1;
      #1;
      checks++; if (feat_bram_addrb !== '0) begin errors++; $display("FAIL basic_first_addr got %0h exp 0", feat_bram_addrb); end
      capture(0, -1, 100);
      extract();
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
      checks++; if (hs_d.size() != DEPTH) begin errors++; $display("FAIL basic_count got %0d exp %0d", hs_d.size(), DEPTH); end
      for (int i = 0; i < hs_d.size() && i < DEPTH; i++) begin
         checks++; if (hs_d[i] !== exp_data(i)) begin errors++; $display("FAIL basic_data[%0d] got %0h exp %0h", i, hs_d[i], exp_data(i)); end
         checks++; if (hs_l[i] !== exp_last(i)) begin errors++; $display("FAIL basic_last[%0d] got %0b exp %0b", i, hs_l[i], exp_last(i)); end
      end
      first_v = -1;
      foreach (v_log[i]) if (first_v < 0 && v_log[i] === 1'b1) first_v = i;
      // log index 0 is one cycle after the edge cycle
      checks++; if (first_v != 1) begin errors++; $display("FAIL basic_latency got %0d exp 1", first_v); end
      for (int k = 0; k < DEPTH - 1 && k < a_log.size(); k++) begin
         checks++;
         if (a_log[k] !== (AW+2)'((k + 1) * 4)) begin
            errors++; $display("FAIL basic_addr[%0d] got %0h exp %0h", k + 1, a_log[k], (k + 1) * 4);
         end
      end
      if (wc_log.size() > 0) begin
         checks++; if (wc_log[wc_log.size()-1] !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL basic_word_cnt got %0d exp %0d", wc_log[wc_log.size()-1], DEPTH); end
         checks++; if (busy_log[busy_log.size()-1] !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got 1 exp 0"); end
      end
      @(negedge clk); gat_ready = 1'b0;
      @(negedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_clear got %0b exp 0", done); end
   endtask

   task automatic test_stall();
      @(negedge clk);
      gat_ready = 1'b1;
      capture(1, -1, 200);
      extract();
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL stall_timeout got 1 exp 0"); end
      checks++; if (hs_d.size() != DEPTH) begin errors++; $display("FAIL stall_count got %0d exp %0d", hs_d.size(), DEPTH); end
      for (int i = 0; i < hs_d.size() && i < DEPTH; i++) begin
         checks++; if (hs_d[i] !== exp_data(i)) begin errors++; $display("FAIL stall_data[%0d] got %0h exp %0h", i, hs_d[i], exp_data(i)); end
         checks++; if (hs_l[i] !== exp_last(i)) begin errors++; $display("FAIL stall_last[%0d] got %0b exp %0b", i, hs_l[i], exp_last(i)); end
      end
      for (int i = 1; i < v_log.size(); i++) begin
         if (v_log[i-1] === 1'b1 && r_log[i-1] === 1'b0) begin
            checks++;
            if (v_log[i] !== 1'b1 || d_log[i] !== d_log[i-1] || l_log[i] !== l_log[i-1]) begin
               errors++;
               $display("FAIL stall_hold[%0d] got v=%0b d=%0h l=%0b exp v=1 d=%0h l=%0b",
                        i, v_log[i], d_log[i], l_log[i], d_log[i-1], l_log[i-1]);
            end
         end
      end
      @(negedge clk); gat_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int  hs;
      bit  got5;
      hs = 0; got5 = 1'b0;
      @(negedge clk);
      gat_ready = 1'b1; m_tready = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk); #1;
         if (m_tvalid && m_tready) hs++;
         if (hs == 5) begin got5 = 1'b1; break; end
      end
      checks++; if (got5 !== 1'b1) begin errors++; $display("FAIL rstmid_reach5 got %0d exp 5", hs); end
      @(negedge clk); #1;
      checks++; if (word_cnt !== (AW+1)'(5)) begin errors++; $display("FAIL rstmid_word_cnt got %0d exp 5", word_cnt); end
      rst = 1'b1; gat_ready = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (feat_bram_addrb !== '0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 ||
          busy !== 1'b0 || done !== 1'b0 || word_cnt !== '0) begin
         errors++;
         $display("FAIL rstmid_zero got a=%0h v=%0b l=%0b d=%0h b=%0b dn=%0b wc=%0d exp all 0",
                  feat_bram_addrb, m_tvalid, m_tlast, m_tdata, busy, done, word_cnt);
      end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         checks++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet[%0d] got v=%0b b=%0b exp 0 0", c, m_tvalid, busy); end
      end
      @(negedge clk);
      gat_ready = 1'b1;
      capture(0, -1, 100);
      extract();
      checks++; if (hs_d.size() != DEPTH) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", hs_d.size(), DEPTH); end
      for (int i = 0; i < hs_d.size() && i < DEPTH; i++) begin
         checks++; if (hs_d[i] !== exp_data(i)) begin errors++; $display("FAIL rstmid_data[%0d] got %0h exp %0h", i, hs_d[i], exp_data(i)); end
      end
      @(negedge clk); gat_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_level_high();
      @(negedge clk);
      rst = 1'b1; gat_ready = 1'b1; m_tready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL level_nostart[%0d] got b=%0b v=%0b exp 0 0", c, busy, m_tvalid); end
      end
      @(negedge clk); gat_ready = 1'b0;
      @(negedge clk); gat_ready = 1'b1;
      capture(0, -1, 100);
      extract();
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL level_timeout got 1 exp 0"); end
      checks++; if (hs_d.size() != DEPTH) begin errors++; $display("FAIL level_count got %0d exp %0d", hs_d.size(), DEPTH); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL level_hold_done[%0d] got dn=%0b b=%0b exp 1 0", c, done, busy); end
      end
      @(negedge clk); gat_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         checks++; if (busy !== 1'b0 || done !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL level_one_frame[%0d] got b=%0b dn=%0b v=%0b exp 0 0 0", c, busy, done, m_tvalid); end
      end
   endtask

   task automatic test_drop_mid();
      @(negedge clk);
      gat_ready = 1'b1; m_tready = 1'b1;
      capture(0, 6, 100);
      extract();
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL drop_timeout got 1 exp 0"); end
      checks++; if (hs_d.size() != DEPTH) begin errors++; $display("FAIL drop_count got %0d exp %0d", hs_d.size(), DEPTH); end
      for (int i = 0; i < hs_d.size() && i < DEPTH; i++) begin
         checks++; if (hs_d[i] !== exp_data(i)) begin errors++; $display("FAIL drop_data[%0d] got %0h exp %0h", i, hs_d[i], exp_data(i)); end
      end
      for (int i = 0; i + 1 < busy_log.size(); i++) begin
         checks++; if (busy_log[i] !== 1'b1) begin errors++; $display("FAIL drop_busy[%0d] got %0b exp 1", i, busy_log[i]); end
      end
      @(negedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_to_idle got dn=%0b b=%0b exp 0 0", done, busy); end
   endtask

   task automatic test_random();
      int d;
      for (int f = 0; f < 4; f++) begin
         @(negedge clk); gat_ready = 1'b0;
         @(negedge clk); gat_ready = 1'b1;
         d = int'($urandom_range(0, DEPTH));
         capture(2, d, 300);
         extract();
         checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout got 1 exp 0", f); end
         checks++; if (hs_d.size() != DEPTH) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", f, hs_d.size(), DEPTH); end
         for (int i = 0; i < hs_d.size() && i < DEPTH; i++) begin
            checks++; if (hs_d[i] !== exp_data(i)) begin errors++; $display("FAIL rand%0d_data[%0d] got %0h exp %0h", f, i, hs_d[i], exp_data(i)); end
            checks++; if (hs_l[i] !== exp_last(i)) begin errors++; $display("FAIL rand%0d_last[%0d] got %0b exp %0b", f, i, hs_l[i], exp_last(i)); end
         end
         @(negedge clk); gat_ready = 1'b0;
         repeat (2) @(negedge clk);
         #1;
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL rand%0d_idle got %0b exp 0", f, done); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_reset_mid();
      test_level_high();
      test_drop_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
